seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor and the successor to the fixed 4-bit ripple-carry adder. It processes a WIDTH-bit operand pair CHUNK bits per clock through one CHUNK-bit ripple-carry slice, keeping the carry in a register between cycles. It uses a start/busy/done handshake. It serves wide arithmetic in lab datapaths, where a full-width ripple chain would be too slow or too large.

---
 rtl/seq_chunk_adder.sv | 124 ++++++++++++
 tb/tb_seq_chunk_adder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit adder/subtractor built around one
// CHUNK-bit ripple-carry slice. Operands are shifted down CHUNK bits per
// clock while the result is shifted in from the top, so after N = WIDTH/CHUNK
// RUN cycles the result register holds the full sum in natural bit order.
// The carry between chunks lives in a register.
// Handshake: start (sampled in IDLE), busy, one-cycle done pulse.
// Optional: define SEQ_CHUNK_ADDER_ZERO_FLAG_EN to add a registered zero flag.
module seq_chunk_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic S_IDLE = 1'b0;
   localparam logic S_RUN  = 1'b1;

   logic             state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] opa;      // operand A, shifted right one chunk per cycle
   logic [WIDTH-1:0] opb;      // operand B (already inverted for subtract)
   logic             a_msb;    // sign bits of the captured operands, kept
   logic             b_msb;    // for the overflow decision at completion
   logic             carry;
   logic [WIDTH-1:0] res;

   logic [CHUNK-1:0] slice_sum;
   logic             slice_cout;
   logic [WIDTH-1:0] res_next;
   logic             last;

   // One CHUNK-bit ripple-carry slice on the low chunk of the shifted operands.
   always_comb begin
      // NOTE: every combinational output gets a default before the loop so no
      // path leaves it unassigned; otherwise synthesis infers a latch.
      slice_sum = '0;
      slice_cout = carry;
      for (int i = 0; i < CHUNK; i++) begin
         slice_sum[i] = opa[i] ^ opb[i] ^ slice_cout;
         slice_cout   = (opa[i] & opb[i]) | (slice_cout & (opa[i] ^ opb[i]));
      end
      // New chunk enters at the top; earlier chunks move down toward bit 0.
      res_next = WIDTH'({slice_sum, res} >> CHUNK);
      last     = (cnt == CW'(N - 1));
   end

   // Control FSM plus datapath registers; all state changes on the rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         opa      <= '0;
         opb      <= '0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         carry    <= 1'b0;
         res      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
         zero     <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so every register samples
         // the values from before this edge regardless of statement order.
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  opa   <= a;
                  opb   <= sub ? ~b : b;
                  a_msb <= a[WIDTH-1];
                  b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                  carry <= sub ? 1'b1 : cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               opa   <= opa >> CHUNK;
               opb   <= opb >> CHUNK;
               res   <= res_next;
               carry <= slice_cout;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  sum      <= res_next;
                  cout     <= slice_cout;
                  overflow <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
                  zero     <= (res_next == '0);
`endif
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed and randomized checks of seq_chunk_adder.
// A 16/4 instance covers the handshake scenarios; three 8-bit instances
// (CHUNK = 1, 2, 8) take random vectors compared against an arithmetic model.
module tb_seq_chunk_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic cin, sub;

   // 16-bit, CHUNK=4 instance
   logic        start16;
   logic [15:0] a16, b16, sum16;
   logic        busy16, done16, cout16, ov16;
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
   logic        zero16;
   logic [2:0]  zero8;
`endif

   // 8-bit instances: index 0 -> CHUNK 1, 1 -> CHUNK 2, 2 -> CHUNK 8
   logic [2:0]  start8, busy8, done8, cout8, ov8;
   logic [7:0]  a8, b8;
   logic [7:0]  sum8 [3];

   int tests = 0;
   int fails = 0;

   seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
      .cin(cin), .sub(sub), .busy(busy16), .done(done16), .sum(sum16),
      .cout(cout16), .overflow(ov16)
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
      , .zero(zero16)
`endif
   );

   seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut8_c1 (
      .clk(clk), .rst_n(rst_n), .start(start8[0]), .a(a8), .b(b8),
      .cin(cin), .sub(sub), .busy(busy8[0]), .done(done8[0]), .sum(sum8[0]),
      .cout(cout8[0]), .overflow(ov8[0])
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
      , .zero(zero8[0])
`endif
   );

   seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut8_c2 (
      .clk(clk), .rst_n(rst_n), .start(start8[1]), .a(a8), .b(b8),
      .cin(cin), .sub(sub), .busy(busy8[1]), .done(done8[1]), .sum(sum8[1]),
      .cout(cout8[1]), .overflow(ov8[1])
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
      , .zero(zero8[1])
`endif
   );

   seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8_c8 (
      .clk(clk), .rst_n(rst_n), .start(start8[2]), .a(a8), .b(b8),
      .cin(cin), .sub(sub), .busy(busy8[2]), .done(done8[2]), .sum(sum8[2]),
      .cout(cout8[2]), .overflow(ov8[2])
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
      , .zero(zero8[2])
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   task automatic ref_model(input int w, input longint ua, input longint ub,
                            input bit ci, input bit sb,
                            output longint s, output bit co, output bit ov);
      longint m, half, sa, sbv, sr, t;
      m    = longint'(1) << w;
      half = m >> 1;
      if (sb) begin
         t  = ua - ub;
         co = (ua >= ub);
      end else begin
         t  = ua + ub + longint'(ci);
         co = (t >= m);
      end
      s   = ((t % m) + m) % m;
      sa  = (ua >= half) ? ua - m : ua;
      sbv = (ub >= half) ? ub - m : ub;
      sr  = sb ? sa - sbv : sa + sbv + longint'(ci);
      ov  = (sr > half - 1) || (sr < -half);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands with start for exactly one edge (E0).
   task automatic go16(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb);
      a16 = av; b16 = bv; cin = ci; sub = sb; start16 = 1'b1;
      tick();
      start16 = 1'b0;
   endtask

   // Count edges after E0 until done is seen; optionally hammer start/operands.
   task automatic wait_done16(input bit noisy, output int cyc);
      cyc = 0;
      while (done16 !== 1'b1 && cyc < 20) begin
         if (noisy) begin
            start16 = 1'b1;
            a16 = 16'($urandom); b16 = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
         end
         tick();
         cyc++;
      end
   endtask

   task automatic check16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic sb);
      longint s; bit co, ov;
      ref_model(16, longint'(av), longint'(bv), ci, sb, s, co, ov);
      check({tag, ".sum"}, 32'(sum16), 32'(s));
      check({tag, ".cout"}, 32'(cout16), 32'(co));
      check({tag, ".ovf"}, 32'(ov16), 32'(ov));
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
      check({tag, ".zero"}, 32'(zero16), 32'(s == 0));
`endif
   endtask

   task automatic run8(input int i, input int n);
      logic [7:0] av, bv; logic ci, sb; int cyc;
      longint s; bit co, ov;
      av = 8'($urandom); bv = 8'($urandom); ci = 1'($urandom); sb = 1'($urandom);
      a8 = av; b8 = bv; cin = ci; sub = sb; start8[i] = 1'b1;
      tick();
      start8[i] = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      cyc = 0;
      while (done8[i] !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      ref_model(8, longint'(av), longint'(bv), ci, sb, s, co, ov);
      check($sformatf("w8c%0d.lat", 8 / n), 32'(cyc), 32'(n));
      check($sformatf("w8c%0d.sum", 8 / n), 32'(sum8[i]), 32'(s));
      check($sformatf("w8c%0d.cout", 8 / n), 32'(cout8[i]), 32'(co));
      check($sformatf("w8c%0d.ovf", 8 / n), 32'(ov8[i]), 32'(ov));
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
      check($sformatf("w8c%0d.zero", 8 / n), 32'(zero8[i]), 32'(s == 0));
`endif
   endtask

   initial begin
      int cyc, cyc2, dcount;

      rst_n = 1'b0; start16 = 1'b0; start8 = '0;
      a16 = '0; b16 = '0; a8 = '0; b8 = '0; cin = 1'b0; sub = 1'b0;
      #12;
      check("rst.busy", 32'(busy16), 32'(0));
      check("rst.done", 32'(done16), 32'(0));
      check("rst.sum", 32'(sum16), 32'(0));
      check("rst.cout", 32'(cout16), 32'(0));
      check("rst.ovf", 32'(ov16), 32'(0));
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
      check("rst.zero", 32'(zero16), 32'(0));
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1: carry ripples through every chunk, exact latency
      go16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      check("t1.busy", 32'(busy16), 32'(1));
      check("t1.sum_hold", 32'(sum16), 32'(0));
      wait_done16(1'b0, cyc);
      check("t1.lat", 32'(cyc), 32'(4));
      check16("t1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      tick();
      check("t1.done_pulse", 32'(done16), 32'(0));

      // 2: subtract with signed overflow, then subtract with borrow
      go16(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_done16(1'b0, cyc);
      check16("t2a", 16'h8000, 16'h0001, 1'b0, 1'b1);
      check("t2a.sum_const", 32'(sum16), 32'h7FFF);
      tick();
      go16(16'h0003, 16'h0005, 1'b1, 1'b1);
      wait_done16(1'b0, cyc);
      check16("t2b", 16'h0003, 16'h0005, 1'b0, 1'b1);
      check("t2b.sum_const", 32'(sum16), 32'hFFFE);
      tick();

      // 3: carry-in, with start and operands toggling throughout the operation
      go16(16'h1234, 16'h4321, 1'b1, 1'b0);
      wait_done16(1'b1, cyc);
      start16 = 1'b0;
      check("t3.lat", 32'(cyc), 32'(4));
      check16("t3", 16'h1234, 16'h4321, 1'b1, 1'b0);
      check("t3.sum_const", 32'(sum16), 32'h5556);
      tick();
      check("t3.idle_after", 32'(busy16), 32'(0));

      // 4: reset mid-operation aborts with no done
      go16(16'hAAAA, 16'h5555, 1'b0, 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      check("t4.busy", 32'(busy16), 32'(0));
      check("t4.done", 32'(done16), 32'(0));
      check("t4.sum", 32'(sum16), 32'(0));
      tick();
      rst_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done16 === 1'b1 || busy16 === 1'b1) dcount++;
      end
      check("t4.no_done", 32'(dcount), 32'(0));

      // 5: back-to-back, start held across done
      a16 = 16'h0102; b16 = 16'h0304; cin = 1'b0; sub = 1'b0; start16 = 1'b1;
      tick();
      a16 = 16'h7FFF; b16 = 16'h0001;
      wait_done16(1'b0, cyc);
      check("t5a.lat", 32'(cyc), 32'(4));
      check16("t5a", 16'h0102, 16'h0304, 1'b0, 1'b0);
      tick();
      start16 = 1'b0;
      wait_done16(1'b0, cyc2);
      check("t5.spacing", 32'(cyc2 + 1), 32'(5));
      check16("t5b", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      tick();

      // 6: random sweep on WIDTH=8 with CHUNK = 1, 2, 8
      for (int k = 0; k < 200; k++) run8(0, 8);
      for (int k = 0; k < 200; k++) run8(1, 4);
      for (int k = 0; k < 200; k++) run8(2, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
